ped_crossing_ctrl: RTL and testbench

Pedestrian-side partner of traffic_light. It debounces a raw crosswalk button and issues the one-cycle pass_request pulse that traffic_light consumes. It also watches traffic_light's red/yellow/green and clock[7:0] countdown outputs to drive the walk and flashing-walk indicators. It sits beside traffic_light on the same clock and reset.

---
 rtl/ped_crossing_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: button debounce, pass_request pulse and walk lamps.
// Optional accepted-request counter enabled by defining PED_REQ_COUNT_EN.
module ped_crossing_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned SHORTEN_TH = 10,
    parameter int unsigned FLASH_TH   = 5,
    parameter int unsigned FLASH_DIV  = 2,
    parameter int unsigned TIMEOUT    = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic [7:0] clock,
    output logic       pass_request,
    output logic       walk,
    output logic       walk_flash,
    output logic       req_pending,
    output logic       fault,
    output logic [7:0] req_count
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_RED,
        WALK,
        CLEAR
    } state_t;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV + 1) : 1;

    localparam logic [7:0]    DEB_MAX  = 8'(DEB_CYCLES);
    localparam logic [7:0]    FLASH_C  = 8'(FLASH_TH);
    localparam logic [7:0]    SHORT_C  = 8'(SHORTEN_TH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FD_LAST  = FW'(FLASH_DIV - 1);

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic [7:0]    deb_cnt;
    logic          press;
    logic [TW-1:0] wait_tmr;
    logic [FW-1:0] flash_tmr;
    logic          legal;
    logic          walk_ok;

    // exactly one lamp lit: odd count, but not all three
    assign legal   = (red ^ yellow ^ green) & ~(red & yellow & green);
    assign walk_ok = clock > FLASH_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_cnt <= 8'd0;
            press   <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            if (!sync2) begin
                deb_cnt <= 8'd0;
            end else if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + 8'd1;
            end
            press <= sync2 && (deb_cnt == DEB_MAX - 8'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pass_request <= 1'b0;
            walk         <= 1'b0;
            walk_flash   <= 1'b0;
            req_pending  <= 1'b0;
            fault        <= 1'b0;
            wait_tmr     <= '0;
            flash_tmr    <= '0;
        end else begin
            pass_request <= 1'b0;
            if (!legal) begin
                fault       <= 1'b1;
                state       <= IDLE;
                walk        <= 1'b0;
                walk_flash  <= 1'b0;
                req_pending <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (press && !fault) begin
                            state       <= ARMED;
                            req_pending <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (red && walk_ok) begin
                            state       <= WALK;
                            walk        <= 1'b1;
                            req_pending <= 1'b0;
                        end else if (green && clock > SHORT_C) begin
                            pass_request <= 1'b1;
                            state        <= WAIT_RED;
                            wait_tmr     <= '0;
                        end
                    end
                    WAIT_RED: begin
                        if (red) begin
                            state       <= WALK;
                            walk        <= walk_ok;
                            req_pending <= 1'b0;
                        end else if (wait_tmr == TMO_LAST) begin
                            state    <= ARMED;
                            wait_tmr <= '0;
                        end else begin
                            wait_tmr <= wait_tmr + TW'(1);
                        end
                    end
                    WALK: begin
                        if (!red) begin
                            state <= IDLE;
                            walk  <= 1'b0;
                        end else if (!walk_ok) begin
                            state      <= CLEAR;
                            walk       <= 1'b0;
                            walk_flash <= 1'b1;
                            flash_tmr  <= '0;
                        end else begin
                            walk <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        if (!red) begin
                            state      <= IDLE;
                            walk_flash <= 1'b0;
                        end else if (flash_tmr == FD_LAST) begin
                            walk_flash <= ~walk_flash;
                            flash_tmr  <= '0;
                        end else begin
                            flash_tmr <= flash_tmr + FW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PED_REQ_COUNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (legal && !fault && press && state == IDLE && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign req_count = cnt_q;
`else
    assign req_count = 8'd0;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scoreboard bench for ped_crossing_ctrl: stimulus queues timed output events,
// a negedge monitor pops one entry per observed output change.
module tb_ped_crossing_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic       red;
    logic       yellow;
    logic       green;
    logic [7:0] clock;
    logic       pass_request;
    logic       walk;
    logic       walk_flash;
    logic       req_pending;
    logic       fault;
    logic [7:0] req_count;

    ped_crossing_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .red          (red),
        .yellow       (yellow),
        .green        (green),
        .clock        (clock),
        .pass_request (pass_request),
        .walk         (walk),
        .walk_flash   (walk_flash),
        .req_pending  (req_pending),
        .fault        (fault),
        .req_count    (req_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] v;
        string      nm;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         cyc = 0;
    int         tests = 0;
    int         failed = 0;
    logic [4:0] cur;
    logic [4:0] prev = 5'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // vector order: {fault, req_pending, walk, walk_flash, pass_request}
    always @(negedge clk) begin
        cur = {fault, req_pending, walk, walk_flash, pass_request};
        if (rst_n === 1'b1 && cur !== prev) begin
            tests++;
            if (q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_change: got %b at cyc %0d, required no change",
                         cur, cyc);
            end else begin
                e = q.pop_front();
                if (cur !== e.v || cyc != e.cyc) begin
                    failed++;
                    $display("FAIL %s: got %b at cyc %0d, required %b at cyc %0d",
                             e.nm, cur, cyc, e.v, e.cyc);
                end
            end
        end
        prev = cur;
    end

    function automatic void push_exp(int c, logic [4:0] v, string nm);
        exp_t t;
        t.cyc = c;
        t.v   = v;
        t.nm  = nm;
        q.push_back(t);
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_light(logic r, logic y, logic g, logic [7:0] c);
        red    = r;
        yellow = y;
        green  = g;
        clock  = c;
    endtask

    task automatic check_direct(string nm, logic [12:0] got, logic [12:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    // red with long countdown: press goes straight to WALK, then red drops
    task automatic walk_cycle(string tag);
        int n;
        n = cyc;
        set_light(1, 0, 0, 8'd12);
        btn_raw = 1'b1;
        push_exp(n + 7,  5'b01000, {tag, "_arm"});
        push_exp(n + 8,  5'b00100, {tag, "_walk"});
        push_exp(n + 13, 5'b00000, {tag, "_idle"});
        tick(8);
        btn_raw = 1'b0;
        tick(4);
        set_light(0, 0, 1, 8'd30);
        tick(4);
    endtask

    initial begin
        int n;
        int m;
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        set_light(0, 0, 1, 8'd30);
        #17;
        rst_n = 1'b1;
        tick(1);
        check_direct("reset_state",
                     {fault, req_pending, walk, walk_flash, pass_request, req_count},
                     13'd0);
        tick(2);

        // long green: press, single pulse, wait for red, walk then flash
        n = cyc;
        set_light(0, 0, 1, 8'd30);
        btn_raw = 1'b1;
        push_exp(n + 7, 5'b01000, "p1_arm");
        push_exp(n + 8, 5'b01001, "p1_pulse");
        push_exp(n + 9, 5'b01000, "p1_pulse_end");
        tick(10);
        btn_raw = 1'b0;
        tick(5);
        set_light(0, 1, 0, 8'd3);
        tick(5);
        m = cyc;
        set_light(1, 0, 0, 8'd30);
        push_exp(m + 1,  5'b00100, "p1_walk");
        push_exp(m + 6,  5'b00010, "p1_clear");
        push_exp(m + 8,  5'b00000, "p1_flash_off");
        push_exp(m + 10, 5'b00010, "p1_flash_on");
        push_exp(m + 12, 5'b00000, "p1_idle");
        tick(5);
        clock = 8'd5;
        tick(6);
        set_light(0, 0, 1, 8'd30);
        tick(3);

        // short green: no pulse, held through yellow, walk on long red
        n = cyc;
        set_light(0, 0, 1, 8'd8);
        btn_raw = 1'b1;
        push_exp(n + 7,  5'b01000, "p2_arm");
        push_exp(n + 15, 5'b00100, "p2_walk");
        push_exp(n + 21, 5'b00010, "p2_clear");
        push_exp(n + 23, 5'b00000, "p2_flash0");
        push_exp(n + 25, 5'b00010, "p2_flash1");
        push_exp(n + 27, 5'b00000, "p2_flash2");
        push_exp(n + 29, 5'b00010, "p2_flash3");
        push_exp(n + 30, 5'b00000, "p2_idle");
        tick(8);
        btn_raw = 1'b0;
        tick(2);
        set_light(0, 1, 0, 8'd3);
        tick(4);
        set_light(1, 0, 0, 8'd20);
        tick(6);
        clock = 8'd5;
        tick(9);
        set_light(0, 0, 1, 8'd30);
        tick(4);

        walk_cycle("p3");

        // no red after pulse: timeout re-arms and re-pulses, then a fault
        n = cyc;
        set_light(0, 0, 1, 8'd40);
        btn_raw = 1'b1;
        push_exp(n + 7,   5'b01000, "p4_arm");
        push_exp(n + 8,   5'b01001, "p4_pulse");
        push_exp(n + 9,   5'b01000, "p4_pulse_end");
        push_exp(n + 209, 5'b01001, "p4_retry_pulse");
        push_exp(n + 210, 5'b01000, "p4_retry_end");
        push_exp(n + 216, 5'b00100, "p4_walk");
        push_exp(n + 221, 5'b10000, "p5_fault");
        tick(8);
        btn_raw = 1'b0;
        tick(207);
        set_light(1, 0, 0, 8'd30);
        tick(5);
        set_light(1, 0, 1, 8'd30);
        tick(1);
        set_light(1, 0, 0, 8'd30);
        tick(4);
        set_light(0, 0, 1, 8'd30);
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(10);

        rst_n = 1'b0;
        #2;
        check_direct("reset_clears_fault",
                     {fault, req_pending, walk, walk_flash, pass_request, req_count},
                     13'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // glitchy button never stays high long enough
        repeat (5) begin
            btn_raw = 1'b1;
            tick(3);
            btn_raw = 1'b0;
            tick(1);
        end
        tick(10);

        walk_cycle("c1");
        walk_cycle("c2");
        walk_cycle("c3");

`ifdef PED_REQ_COUNT_EN
        check_direct("req_count", {5'd0, req_count}, 13'd3);
`else
        check_direct("req_count", {5'd0, req_count}, 13'd0);
`endif
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL missing_events: got %0d pending, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
